// File: rtl/background.sv
// background -- tile-based background renderer for the VGA pixel pipeline.
//
// Maps the current pixel to a tilemap cell, looks the texel up in an internal
// tile ROM and drives 4-bit R/G/B to the sprite/overlay mixer. The map covers
// NUM_TILES_X x NUM_TILES_Y tiles of TILE_WIDTH x TILE_HEIGHT px; everything
// outside it, and any cell holding an index >= NUM_TILE_TYPES, shows bg_color.
//
// Latency is 3 clk from curr_x/curr_y to o_pix_*, one pixel per clock, no stall.
//
// Optional build macro: BG_TRANSPARENCY_EN -- when defined, an in-map texel equal
// to TRANSP_COLOR is replaced by bg_color. Undefined: texels pass verbatim.
//
// The ROM holds the built-in pattern {idx[3:0],row[3:0],col[3:0]}
// (entry = idx*TW*TH + row*TW + col); TILE_ROM_FILE is kept for compatibility.
//
// Ports:
//   clk       pixel clock
//   rst       synchronous, active-high reset; clears every pipeline register
//   curr_x    current pixel column (11 bit)
//   curr_y    current pixel row (10 bit)
//   tilemap   tile index per cell, [row][col]; level input, sampled in stage 1
//   bg_color  fill colour, sampled when the output register loads
//   o_pix_r/g/b  4-bit colour components
module background #(
  parameter int unsigned              TILE_WIDTH     = 32,
  parameter int unsigned              TILE_HEIGHT    = 32,
  parameter int unsigned              NUM_TILES_X    = 40,
  parameter int unsigned              NUM_TILES_Y    = 25,
  parameter int unsigned              COLOR_WIDTH    = 12,
  parameter int unsigned              TILE_IDX_WIDTH = 5,
  parameter int unsigned              NUM_TILE_TYPES = 19,
  parameter string                    TILE_ROM_FILE  = "tiles.mem",
  parameter logic [COLOR_WIDTH-1:0]   TRANSP_COLOR   = 12'hF0F
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               curr_x,
  input  logic [9:0]                curr_y,
  input  logic [TILE_IDX_WIDTH-1:0] tilemap [0:NUM_TILES_Y-1][0:NUM_TILES_X-1],
  input  logic [COLOR_WIDTH-1:0]    bg_color,
  output logic [3:0]                o_pix_r,
  output logic [3:0]                o_pix_g,
  output logic [3:0]                o_pix_b
);

  localparam int unsigned XB          = $clog2(TILE_WIDTH);
  localparam int unsigned YB          = $clog2(TILE_HEIGHT);
  localparam int unsigned TXW         = 11 - XB;
  localparam int unsigned TYW         = 10 - YB;
  localparam int unsigned AW          = TILE_IDX_WIDTH + YB + XB;
  localparam int unsigned TILE_TEXELS = TILE_WIDTH * TILE_HEIGHT;
  localparam int unsigned ROM_DEPTH   = NUM_TILE_TYPES * TILE_TEXELS;

`ifdef BG_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef logic [COLOR_WIDTH-1:0] rom_t [ROM_DEPTH];

  function automatic rom_t load_rom();
    rom_t m;
    for (int unsigned a = 0; a < ROM_DEPTH; a++) begin
      m[a] = COLOR_WIDTH'({4'(a / TILE_TEXELS),
                           4'((a / TILE_WIDTH) % TILE_HEIGHT),
                           4'(a % TILE_WIDTH)});
    end
    return m;
  endfunction

  logic [COLOR_WIDTH-1:0] rom [ROM_DEPTH] = load_rom();

  // Stage-0 combinational decode
  logic [TXW-1:0]            tx;
  logic [TYW-1:0]            ty;
  logic [XB-1:0]             px_c;
  logic [YB-1:0]             py_c;
  logic                      in_map_c;
  logic [TILE_IDX_WIDTH-1:0] idx_c;
  logic                      idx_ok_c;

  always_comb begin
    tx       = curr_x[10:XB];
    ty       = curr_y[9:YB];
    px_c     = curr_x[XB-1:0];
    py_c     = curr_y[YB-1:0];
    in_map_c = (32'(tx) < NUM_TILES_X) && (32'(ty) < NUM_TILES_Y);
    idx_c    = '0;
    if (in_map_c) idx_c = tilemap[ty][tx];
    idx_ok_c = 32'(idx_c) < NUM_TILE_TYPES;
  end

  // Pipeline registers; v1/v2 mark stages holding a coordinate accepted after
  // reset so the output stays 0 (not bg_color) while the pipeline refills.
  logic                      v1, v2;
  logic [XB-1:0]             s1_px;
  logic [YB-1:0]             s1_py;
  logic                      s1_in_map, s1_idx_ok;
  logic [TILE_IDX_WIDTH-1:0] s1_idx;
  logic                      s2_in_map, s2_idx_ok;
  logic [COLOR_WIDTH-1:0]    rom_q;
  logic [COLOR_WIDTH-1:0]    pix;
  logic [AW-1:0]             rom_addr;
  logic                      key_hit;

  // Power-of-two tile sizes turn idx*TW*TH + py*TW + px into a concatenation.
  assign rom_addr = {s1_idx, s1_py, s1_px};
  assign key_hit  = KEY_EN && (rom_q == TRANSP_COLOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s1_px     <= '0;
      s1_py     <= '0;
      s1_in_map <= 1'b0;
      s1_idx_ok <= 1'b0;
      s1_idx    <= '0;
      s2_in_map <= 1'b0;
      s2_idx_ok <= 1'b0;
      rom_q     <= '0;
      pix       <= '0;
    end else begin
      v1        <= 1'b1;
      s1_px     <= px_c;
      s1_py     <= py_c;
      s1_in_map <= in_map_c;
      s1_idx_ok <= idx_ok_c;
      s1_idx    <= idx_c;

      v2        <= v1;
      s2_in_map <= s1_in_map;
      s2_idx_ok <= s1_idx_ok;
      rom_q     <= rom[rom_addr];

      if (!v2)
        pix <= '0;
      else if (s2_in_map && s2_idx_ok && !key_hit)
        pix <= rom_q;
      else
        pix <= bg_color;
    end
  end

  assign {o_pix_r, o_pix_g, o_pix_b} = pix;

endmodule

// File: tb/tb_background.sv
// tb_background -- randomized, self-checking bench for the tile background renderer.
// A reference model computes each pixel from the tile/pixel arithmetic and a
// 3-stage delay line; directed probes cover named cells and map boundaries.
module tb_background;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic [4:0]  tm [0:24][0:39];
  logic [11:0] bg_color;
  logic [3:0]  o_pix_r, o_pix_g, o_pix_b;

  int checks = 0;
  int errors = 0;

  // model delay line: coordinate result sampled one and two edges ago
  bit          m1_v = 0, m2_v = 0;
  bit          m1_bg = 0, m2_bg = 0;
  logic [11:0] m1_tex = '0, m2_tex = '0;

  background #(
    .TILE_ROM_FILE("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .curr_x   (curr_x),
    .curr_y   (curr_y),
    .tilemap  (tm),
    .bg_color (bg_color),
    .o_pix_r  (o_pix_r),
    .o_pix_g  (o_pix_g),
    .o_pix_b  (o_pix_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // {use_bg, texel} for a pixel, from the current tilemap contents
  function automatic logic [12:0] ref_pix(input int x, input int y);
    int idx;
    logic [11:0] tex;
    if (x >= 1280 || y >= 800) return {1'b1, 12'h000};
    idx = int'(tm[y / 32][x / 32]);
    if (idx >= 19) return {1'b1, 12'h000};
    tex = 12'((idx % 16) * 256 + (y % 16) * 16 + (x % 16));
`ifdef BG_TRANSPARENCY_EN
    if (tex == 12'hF0F) return {1'b1, 12'h000};
`endif
    return {1'b0, tex};
  endfunction

  task automatic cycle(input bit r_v, input int x, input int y, input logic [11:0] bg,
                       input string tag);
    logic [12:0] e;
    logic [11:0] exp;
    rst      = r_v;
    curr_x   = 11'(x);
    curr_y   = 10'(y);
    bg_color = bg;
    e = ref_pix(x, y);
    @(posedge clk);
    #1;
    if (r_v || !m2_v) exp = 12'h000;
    else              exp = m2_bg ? bg : m2_tex;
    check(tag, {o_pix_r, o_pix_g, o_pix_b}, exp);
    m2_v   = m1_v && !r_v;
    m2_bg  = m1_bg;
    m2_tex = m1_tex;
    m1_v   = !r_v;
    m1_bg  = e[12];
    m1_tex = e[11:0];
  endtask

  // feed one coordinate, hold it, and compare the pixel 3 clk later to a constant
  task automatic probe(input int x, input int y, input logic [11:0] bg,
                       input logic [11:0] exp, input string tag);
    cycle(0, x, y, bg, "pipe");
    cycle(0, x, y, bg, "pipe");
    cycle(0, x, y, bg, "pipe");
    check(tag, {o_pix_r, o_pix_g, o_pix_b}, exp);
  endtask

  initial begin
    int ys[7];
    logic [11:0] tp_exp;
    ys = '{0, 1, 17, 31, 32, 500, 799};
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 40; c++) tm[r][c] = '0;

    // reset state
    for (int i = 0; i < 4; i++) cycle(1, 100, 100, 12'hFFF, "reset");
    check("reset_out", {o_pix_r, o_pix_g, o_pix_b}, 12'h000);

    // tilemap all 0, bg 0: row sweeps (first pixels after reset read 0)
    foreach (ys[k])
      for (int x = 0; x < 1280; x += ((k % 2) == 0 ? 1 : 7)) cycle(0, x, ys[k], 12'h000, "sweep");

    // map edges, including one past the last tile row/column
    for (int y = 798; y <= 801; y++)
      for (int x = 1270; x <= 1290; x++) cycle(0, x, y, 12'h000, "edge");

    // directed cells
    tm[5][10] = 5'd3;
    probe(330, 165, 12'h000, 12'h35A, "tile3");
    probe(319, 165, 12'h000, 12'h05F, "tile3_neigh");
    tm[7][12] = 5'd18;
    probe(400, 230, 12'h000, 12'h260, "tile18");
    tm[0][0] = 5'd25;
    probe(0, 0, 12'hABC, 12'hABC, "bad_idx_a");
    probe(31, 31, 12'hABC, 12'hABC, "bad_idx_b");
    probe(32, 0, 12'hABC, 12'h000, "bad_idx_next");
    probe(1280, 0, 12'h123, 12'h123, "x_out");
    probe(0, 800, 12'h123, 12'h123, "y_out");
    probe(1279, 799, 12'h123, 12'h0FF, "last_in");
    probe(2047, 1023, 12'h123, 12'h123, "far_out");

    // colour key texel F0F = (idx 15, row 0, col 15)
    tm[1][2] = 5'd15;
`ifdef BG_TRANSPARENCY_EN
    tp_exp = 12'h555;
`else
    tp_exp = 12'hF0F;
`endif
    probe(79, 32, 12'h555, tp_exp, "transp");
    probe(78, 32, 12'h555, 12'hF0E, "transp_neigh");

    // mid-sweep reset pulse
    for (int x = 600; x < 640; x++) cycle(0, x, 400, 12'h0A0, "pre_rst");
    cycle(1, 640, 400, 12'h0A0, "mid_rst");
    for (int x = 641; x < 660; x++) cycle(0, x, 400, 12'h0A0, "post_rst");

    // randomized traffic with tilemap edits and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)
        tm[$urandom_range(0, 24)][$urandom_range(0, 39)] = 5'($urandom_range(0, 31));
      cycle($urandom_range(0, 149) == 0, int'($urandom_range(0, 1400)),
            int'($urandom_range(0, 900)), 12'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
